// File: rtl/ysyx_22040127_mem_arbiter.sv
// Shares one line-refill memory port between icache and dcache, one transaction at a time.
// The dcache has priority; a streak counter hands a grant to a waiting icache every D_STREAK dcache grants.
module ysyx_22040127_mem_arbiter #(
  parameter int LINE_W   = 128,
  parameter int D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_valid,
  input  logic [63:0]       ic_req_addr,
  output logic              ic_res_valid,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req_valid,
  input  logic              dc_req_write,
  input  logic [63:0]       dc_req_addr,
  input  logic [LINE_W-1:0] dc_req_wdata,
  output logic              dc_res_valid,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [63:0]       mem_req_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_res_valid,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int SW = $clog2(D_STREAK + 1);
  localparam logic [63:0] LINE_MASK = 64'hffffffff_fffffff0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e            state_q;
  logic              owner_q;  // 1 = dcache owns the transaction
  logic [SW-1:0]     streak_q, streak_d;
  logic              grant_dc_d;
  logic              mem_req_valid_q, mem_req_write_q;
  logic [63:0]       mem_req_addr_q;
  logic [LINE_W-1:0] mem_wdata_q, ic_rdata_q, dc_rdata_q;
  logic              ic_res_valid_q, dc_res_valid_q;

  // dcache wins a tie unless it has already starved a waiting icache D_STREAK times
  always_comb begin
    grant_dc_d = dc_req_valid && !(ic_req_valid && streak_q == SW'(D_STREAK));
    streak_d   = '0;
    if (grant_dc_d && ic_req_valid)
      streak_d = (streak_q == SW'(D_STREAK)) ? streak_q : streak_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      owner_q         <= 1'b0;
      streak_q        <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_write_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_wdata_q     <= '0;
      ic_rdata_q      <= '0;
      dc_rdata_q      <= '0;
      ic_res_valid_q  <= 1'b0;
      dc_res_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (ic_req_valid || dc_req_valid) begin
          owner_q         <= grant_dc_d;
          streak_q        <= streak_d;
          mem_req_valid_q <= 1'b1;
          mem_req_addr_q  <= (grant_dc_d ? dc_req_addr : ic_req_addr) & LINE_MASK;
          mem_req_write_q <= grant_dc_d && dc_req_write;
          mem_wdata_q     <= (grant_dc_d && dc_req_write) ? dc_req_wdata : '0;
          state_q         <= ISSUE;
        end
        ISSUE: if (mem_req_ready) begin
          mem_req_valid_q <= 1'b0;
          state_q         <= WAIT;
        end
        WAIT: if (mem_res_valid) begin
          if (!owner_q) begin
            ic_rdata_q     <= mem_rdata;
            ic_res_valid_q <= 1'b1;
          end else begin
            // a writeback ack carries no data, so the last refill line stays visible
            if (!mem_req_write_q) dc_rdata_q <= mem_rdata;
            dc_res_valid_q <= 1'b1;
          end
          state_q <= DONE;
        end
        DONE: begin
          ic_res_valid_q <= 1'b0;
          dc_res_valid_q <= 1'b0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_write = mem_req_write_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign ic_res_valid  = ic_res_valid_q;
  assign dc_res_valid  = dc_res_valid_q;
  assign ic_rdata      = ic_rdata_q;
  assign dc_rdata      = dc_rdata_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_ysyx_22040127_mem_arbiter.sv
// Randomized bench: two requesters and a memory model, checked against a transaction-level arbiter model.
module tb_ysyx_22040127_mem_arbiter;
  localparam int D_STREAK = 4;
  localparam logic [63:0] MASK = 64'hffffffff_fffffff0;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_req_valid, dc_req_valid, dc_req_write;
  logic [63:0]  ic_req_addr, dc_req_addr;
  logic [127:0] dc_req_wdata, ic_rdata, dc_rdata, mem_wdata, mem_rdata;
  logic         ic_res_valid, dc_res_valid;
  logic         mem_req_valid, mem_req_ready, mem_req_write, mem_res_valid, busy;
  logic [63:0]  mem_req_addr;

  always #5 clk = ~clk;

  ysyx_22040127_mem_arbiter #(.LINE_W(128), .D_STREAK(D_STREAK)) dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
    .ic_res_valid(ic_res_valid), .ic_rdata(ic_rdata),
    .dc_req_valid(dc_req_valid), .dc_req_write(dc_req_write),
    .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata),
    .dc_res_valid(dc_res_valid), .dc_rdata(dc_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_wdata(mem_wdata), .mem_res_valid(mem_res_valid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // transaction-level reference state
  bit           m_busy, m_issue, m_waiting, m_pulse_prev;
  bit           m_own_ic, m_wr;
  logic [63:0]  m_addr;
  logic [127:0] m_wdata, m_ic_line, m_dc_line;
  int           dc_run, resp_cnt, n_ic_grants, n_dc_grants;
  // requesters
  bit           ic_pend, ic_drop, dc_pend;
  int           p_req, p_drop;

  task automatic model_reset();
    m_busy = 0; m_issue = 0; m_waiting = 0; m_pulse_prev = 0;
    m_own_ic = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
    m_ic_line = '0; m_dc_line = '0; dc_run = 0; resp_cnt = 0;
    ic_pend = 0; ic_drop = 0; dc_pend = 0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cycle();
    bit pulse_ic, pulse_dc, icv, dcv, rdy, mrv;
    logic [127:0] mrd;
    icv = ic_req_valid; dcv = dc_req_valid; rdy = mem_req_ready;
    mrv = mem_res_valid; mrd = mem_rdata;
    @(posedge clk); #1;
    // response: the line goes back to whoever owns the transaction, one cycle later
    pulse_ic = mrv && m_waiting && m_own_ic;
    pulse_dc = mrv && m_waiting && !m_own_ic;
    if (mrv && m_waiting) begin
      m_waiting = 0;
      if (m_own_ic) m_ic_line = mrd;
      else if (!m_wr) m_dc_line = mrd;
    end
    if (m_issue && rdy) begin
      m_issue = 0; m_waiting = 1; resp_cnt = $urandom_range(0, 3);
    end
    if (!m_busy && (icv || dcv)) begin
      m_own_ic = icv && (!dcv || dc_run == D_STREAK);
      if (m_own_ic) begin
        dc_run = 0; n_ic_grants++;
        m_addr = ic_req_addr & MASK; m_wr = 0; m_wdata = '0;
      end else begin
        dc_run = icv ? ((dc_run == D_STREAK) ? dc_run : dc_run + 1) : 0; n_dc_grants++;
        m_addr = dc_req_addr & MASK; m_wr = dc_req_write;
        m_wdata = dc_req_write ? dc_req_wdata : '0;
      end
      m_busy = 1; m_issue = 1;
    end else if (m_busy && m_pulse_prev) m_busy = 0;
    m_pulse_prev = pulse_ic || pulse_dc;

    chk("ic_res_valid", 128'(ic_res_valid), 128'(pulse_ic));
    chk("dc_res_valid", 128'(dc_res_valid), 128'(pulse_dc));
    chk("busy", 128'(busy), 128'(m_busy));
    chk("mem_req_valid", 128'(mem_req_valid), 128'(m_issue));
    if (m_issue) begin
      chk("mem_req_addr", 128'(mem_req_addr), 128'(m_addr));
      chk("mem_req_write", 128'(mem_req_write), 128'(m_wr));
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (pulse_ic || pulse_dc) begin
      chk("ic_rdata", ic_rdata, m_ic_line);
      chk("dc_rdata", dc_rdata, m_dc_line);
    end

    // memory side
    mem_res_valid = 1'b0;
    mem_rdata = rnd128();
    if (m_waiting) begin
      if (resp_cnt == 0) mem_res_valid = 1'b1;
      else resp_cnt--;
    end
    mem_req_ready = ($urandom_range(0, 1) == 1);

    // requesters
    if (pulse_ic) begin ic_pend = 0; ic_drop = 0; end
    if (pulse_dc) dc_pend = 0;
    if (ic_pend && m_busy && m_own_ic && !ic_drop && $urandom_range(0, 99) < p_drop) ic_drop = 1;
    if (!ic_pend && $urandom_range(0, 99) < p_req) begin
      ic_pend = 1; ic_req_addr = {$urandom, $urandom};
    end
    if (!dc_pend && $urandom_range(0, 99) < p_req) begin
      dc_pend = 1; dc_req_addr = {$urandom, $urandom};
      dc_req_write = ($urandom_range(0, 2) == 0); dc_req_wdata = rnd128();
    end
    ic_req_valid = ic_pend && !ic_drop;
    dc_req_valid = dc_pend;
    if (!ic_req_valid) ic_req_addr = {$urandom, $urandom};
    if (!dc_req_valid) begin
      dc_req_addr = {$urandom, $urandom}; dc_req_wdata = rnd128();
      dc_req_write = $urandom_range(0, 1) == 1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_req_valid"}, 128'(mem_req_valid), 128'd0);
    chk({tag, ".mem_req_write"}, 128'(mem_req_write), 128'd0);
    chk({tag, ".mem_req_addr"}, 128'(mem_req_addr), 128'd0);
    chk({tag, ".mem_wdata"}, mem_wdata, 128'd0);
    chk({tag, ".ic_res_valid"}, 128'(ic_res_valid), 128'd0);
    chk({tag, ".dc_res_valid"}, 128'(dc_res_valid), 128'd0);
    chk({tag, ".ic_rdata"}, ic_rdata, 128'd0);
    chk({tag, ".dc_rdata"}, dc_rdata, 128'd0);
    chk({tag, ".busy"}, 128'(busy), 128'd0);
  endtask

  initial begin
    int guard;
    rst = 1'b0;
    ic_req_valid = 0; dc_req_valid = 0; dc_req_write = 0;
    ic_req_addr = '0; dc_req_addr = '0; dc_req_wdata = '0;
    mem_req_ready = 0; mem_res_valid = 0; mem_rdata = '0;
    n_ic_grants = 0; n_dc_grants = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;

    // both requesters always busy: exercises the streak hand-off
    p_req = 100; p_drop = 0;
    repeat (300) cycle();
    // sparse traffic with icache redirects
    p_req = 30; p_drop = 30;
    repeat (1500) cycle();
    p_req = 70; p_drop = 15;
    repeat (1500) cycle();
    chk("ic_grants_seen", 128'(n_ic_grants > 20), 128'd1);
    chk("dc_grants_seen", 128'(n_dc_grants > 20), 128'd1);

    // reset while a transaction waits for memory
    guard = 0;
    while (!(m_busy && m_waiting && !m_pulse_prev) && guard < 500) begin
      cycle(); guard++;
    end
    chk("found_wait_state", 128'(guard < 500), 128'd1);
    rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    ic_req_valid = 0; dc_req_valid = 0;
    mem_res_valid = 1'b1; mem_rdata = rnd128();
    @(posedge clk); #1;
    chk_all_zero("held_reset");
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_reset.ic_res_valid", 128'(ic_res_valid), 128'd0);
      chk("post_reset.dc_res_valid", 128'(dc_res_valid), 128'd0);
      chk("post_reset.busy", 128'(busy), 128'd0);
      mem_res_valid = 1'b0;
    end
    model_reset();
    p_req = 50; p_drop = 20;
    repeat (300) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
